// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: register address
// width, forwarding-select encodings, hazard FSM states and stall-cause codes.
package mips_pkg;

  localparam int REG_AW = 5;

  // ALU operand / comparator forwarding selects
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Stall-episode tracker states
  typedef enum logic [2:0] {
    RUN,
    LU,
    BR_ALU,
    BR_LD1,
    BR_LD2
  } hz_state_t;

  // Stall cause codes
  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_LU     = 2'd1;
  localparam logic [1:0] CAUSE_BR_ALU = 2'd2;
  localparam logic [1:0] CAUSE_BR_LD  = 2'd3;

  // Map a tracker state to the cause it reports
  function automatic logic [1:0] cause_of(input hz_state_t s);
    logic [1:0] c;
    c = CAUSE_NONE;
    case (s)
      LU:             c = CAUSE_LU;
      BR_ALU:         c = CAUSE_BR_ALU;
      BR_LD1, BR_LD2: c = CAUSE_BR_LD;
      default:        c = CAUSE_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle of pipeline-register/forwarding signals seen by the hazard controller.
// slave = the controller, master = the pipeline datapath driving it.
interface hazard_stall_ctrl_if #(
  parameter int REG_AW = mips_pkg::REG_AW
);

  logic [REG_AW-1:0] rs_ID;
  logic [REG_AW-1:0] rt_ID;
  logic              branch_ID;
  logic [REG_AW-1:0] rs_EX;
  logic [REG_AW-1:0] rt_EX;
  logic [REG_AW-1:0] WriteReg_EX;
  logic [REG_AW-1:0] WriteReg_MEM;
  logic [REG_AW-1:0] WriteReg_WB;
  logic              RegWrite_EX;
  logic              RegWrite_MEM;
  logic              RegWrite_WB;
  logic              MemtoReg_EX;
  logic              MemtoReg_MEM;
  logic              perf_clr;

  logic              stall_IF;
  logic              stall_ID;
  logic              flush_EX;
  logic              fwdA_ID;
  logic              fwdB_ID;
  logic [1:0]        fwdA_EX;
  logic [1:0]        fwdB_EX;
  logic [1:0]        stall_cause;
  logic              hazard_err;
  logic [31:0]       stall_cycles;
  logic [15:0]       lu_events;
  logic [15:0]       br_events;

  modport slave (
    input  rs_ID, rt_ID, branch_ID, rs_EX, rt_EX,
    input  WriteReg_EX, WriteReg_MEM, WriteReg_WB,
    input  RegWrite_EX, RegWrite_MEM, RegWrite_WB,
    input  MemtoReg_EX, MemtoReg_MEM, perf_clr,
    output stall_IF, stall_ID, flush_EX, fwdA_ID, fwdB_ID,
    output fwdA_EX, fwdB_EX, stall_cause, hazard_err,
    output stall_cycles, lu_events, br_events
  );

  modport master (
    output rs_ID, rt_ID, branch_ID, rs_EX, rt_EX,
    output WriteReg_EX, WriteReg_MEM, WriteReg_WB,
    output RegWrite_EX, RegWrite_MEM, RegWrite_WB,
    output MemtoReg_EX, MemtoReg_MEM, perf_clr,
    input  stall_IF, stall_ID, flush_EX, fwdA_ID, fwdB_ID,
    input  fwdA_EX, fwdB_EX, stall_cause, hazard_err,
    input  stall_cycles, lu_events, br_events
  );

endinterface

// File: rtl/hazard_perf_cnt.sv
// Saturating stall/event counters for the hazard controller.
// Only built when HAZARD_PERF_CNT_EN is defined.
`ifdef HAZARD_PERF_CNT_EN
module hazard_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        perf_clr,
  input  logic        stall,
  input  logic        lu_evt,
  input  logic        br_evt,
  output logic [31:0] stall_cycles,
  output logic [15:0] lu_events,
  output logic [15:0] br_events
);

  // Count stall cycles and episode starts; clear beats a same-edge increment
  always_ff @(posedge clk) begin
    if (reset || perf_clr) begin
      stall_cycles <= '0;
      lu_events    <= '0;
      br_events    <= '0;
    end else begin
      if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
      if (lu_evt && (lu_events != '1))   lu_events    <= lu_events + 16'd1;
      if (br_evt && (br_events != '1))   br_events    <= br_events + 16'd1;
    end
  end

endmodule
`endif

// File: rtl/hazard_stall_ctrl.sv
// Hazard controller for the 5-stage MIPS core: load-use and branch-operand
// stall detection, ID/EX bubble insertion, EX and ID forwarding selects, and a
// stall-episode tracker reporting cause and over-long stalls.
// Optional macro HAZARD_PERF_CNT_EN builds the performance counters.
module hazard_stall_ctrl #(
  parameter int REG_AW    = 5,
  parameter int MAX_STALL = 2
) (
  input  logic                clk,
  input  logic                reset,
  hazard_stall_ctrl_if.slave  bus
);
  import mips_pkg::*;

  localparam logic [7:0] MAX_STALL_C = 8'(MAX_STALL);

  // True when a nonzero destination register feeds either source
  function automatic logic reg_hit(input logic [REG_AW-1:0] wr,
                                   input logic [REG_AW-1:0] a,
                                   input logic [REG_AW-1:0] b);
    return (wr != '0) && ((wr == a) || (wr == b));
  endfunction

  // Forwarding select for one EX operand; MEM result is newer than WB
  function automatic logic [1:0] ex_sel(input logic [REG_AW-1:0] src,
                                        input logic              we_mem,
                                        input logic [REG_AW-1:0] wr_mem,
                                        input logic              we_wb,
                                        input logic [REG_AW-1:0] wr_wb);
    logic [1:0] s;
    s = FWD_REG;
    if (we_mem && (wr_mem != '0) && (wr_mem == src))  s = FWD_MEM;
    else if (we_wb && (wr_wb != '0) && (wr_wb == src)) s = FWD_WB;
    return s;
  endfunction

  logic [REG_AW-1:0] rs_id, rt_id, rs_ex, rt_ex;
  logic [REG_AW-1:0] wr_ex, wr_mem, wr_wb;

  assign rs_id  = bus.rs_ID;
  assign rt_id  = bus.rt_ID;
  assign rs_ex  = bus.rs_EX;
  assign rt_ex  = bus.rt_EX;
  assign wr_ex  = bus.WriteReg_EX;
  assign wr_mem = bus.WriteReg_MEM;
  assign wr_wb  = bus.WriteReg_WB;

  logic hit_ex, hit_mem;
  logic lu, b_alu, b_ld, b_ld_ex;
  logic hazard, stall;

  assign hit_ex  = reg_hit(wr_ex, rs_id, rt_id);
  assign hit_mem = reg_hit(wr_mem, rs_id, rt_id);

  assign lu      = bus.MemtoReg_EX & hit_ex;
  assign b_alu   = bus.branch_ID & bus.RegWrite_EX & hit_ex;
  assign b_ld    = bus.branch_ID & bus.MemtoReg_MEM & hit_mem;
  // Branch waiting on a load still in EX: needs two bubbles
  assign b_ld_ex = bus.branch_ID & bus.MemtoReg_EX & hit_ex;

  assign hazard  = lu | b_alu | b_ld;
  // Hold/flush are suppressed while the pipeline is being reset
  assign stall   = hazard & ~reset;

  assign bus.stall_IF = stall;
  assign bus.stall_ID = stall;
  assign bus.flush_EX = stall;

  // Branch comparator only forwards ALU results from MEM, never load data
  assign bus.fwdA_ID = bus.RegWrite_MEM & ~bus.MemtoReg_MEM & (wr_mem != '0) & (wr_mem == rs_id);
  assign bus.fwdB_ID = bus.RegWrite_MEM & ~bus.MemtoReg_MEM & (wr_mem != '0) & (wr_mem == rt_id);

  assign bus.fwdA_EX = ex_sel(rs_ex, bus.RegWrite_MEM, wr_mem, bus.RegWrite_WB, wr_wb);
  assign bus.fwdB_EX = ex_sel(rt_ex, bus.RegWrite_MEM, wr_mem, bus.RegWrite_WB, wr_wb);

  hz_state_t  state, state_next;
  logic [1:0] cause_q;
  logic [7:0] run_cnt;
  logic       err_q;

  // Stall-episode state register
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Episode classification; a branch on a load in EX takes the two-cycle path
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (b_ld_ex)    state_next = BR_LD1;
        else if (b_alu) state_next = BR_ALU;
        else if (b_ld)  state_next = BR_LD2;
        else if (lu)    state_next = LU;
        else            state_next = RUN;
      end
      BR_LD1:            state_next = hazard ? BR_LD2 : RUN;
      LU, BR_ALU, BR_LD2: state_next = hazard ? state : RUN;
      default:           state_next = RUN;
    endcase
  end

  // Cause reflects the episode the pipeline is currently in
  always_ff @(posedge clk) begin
    if (reset) cause_q <= CAUSE_NONE;
    else       cause_q <= cause_of(state_next);
  end

  // Consecutive stall-cycle length, saturating
  always_ff @(posedge clk) begin
    if (reset)                 run_cnt <= '0;
    else if (!stall)           run_cnt <= '0;
    else if (run_cnt != 8'hFF) run_cnt <= run_cnt + 8'd1;
  end

  // Sticky flag once a stall run grows past the legal length
  always_ff @(posedge clk) begin
    if (reset)                                err_q <= 1'b0;
    else if (stall && (run_cnt >= MAX_STALL_C)) err_q <= 1'b1;
  end

  assign bus.stall_cause = cause_q;
  assign bus.hazard_err  = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic lu_evt, br_evt;

  assign lu_evt = (state == RUN) && (state_next == LU);
  assign br_evt = (state == RUN) &&
                  ((state_next == BR_ALU) || (state_next == BR_LD1) || (state_next == BR_LD2));

  hazard_perf_cnt u_perf (
    .clk          (clk),
    .reset        (reset),
    .perf_clr     (bus.perf_clr),
    .stall        (stall),
    .lu_evt       (lu_evt),
    .br_evt       (br_evt),
    .stall_cycles (bus.stall_cycles),
    .lu_events    (bus.lu_events),
    .br_events    (bus.br_events)
  );
`else
  logic unused_perf_clr;

  assign unused_perf_clr  = bus.perf_clr;
  assign bus.stall_cycles = '0;
  assign bus.lu_events    = '0;
  assign bus.br_events    = '0;
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It detects load-use and branch-operand hazards, and drives the hold (`stall`) input of the IF/ID pipeline register and the PC register. It also inserts bubbles into ID/EX and produces EX-stage and ID-stage (branch comparator) forwarding selects. A small FSM tracks each stall episode, reports its cause, and flags illegal stall lengths.

## Interface
Parameters:
- `REG_AW`, default 5: register address width.
- `MAX_STALL`, default 2: maximum legal consecutive stall cycles for one ID instruction.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: reset, synchronous, active-high.
- `rs_ID`, `rt_ID`, input, `REG_AW`: source registers of the instruction in ID.
- `branch_ID`, input, 1: ID holds a beq/bne (resolved in ID).
- `rs_EX`, `rt_EX`, input, `REG_AW`: source registers in EX.
- `WriteReg_EX`, `WriteReg_MEM`, `WriteReg_WB`, input, `REG_AW` each: destination registers.
- `RegWrite_EX`, `RegWrite_MEM`, `RegWrite_WB`, input, 1 each: writeback enables.
- `MemtoReg_EX`, `MemtoReg_MEM`, input, 1 each: stage holds a load.
- `stall_IF`, output, 1: hold PC.
- `stall_ID`, output, 1: hold IF/ID register (its `stall` input).
- `flush_EX`, output, 1: zero ID/EX control (bubble).
- `fwdA_ID`, `fwdB_ID`, output, 1 each: branch comparator takes the MEM ALU result.
- `fwdA_EX`, `fwdB_EX`, output, 2 each: ALU operand select (00 reg, 01 WB, 10 MEM).
- `stall_cause`, output, 2: 0 none, 1 load-use, 2 branch-ALU, 3 branch-load.
- `hazard_err`, output, 1: sticky; a stall run exceeded `MAX_STALL`.
- `perf_clr`, input, 1: clear counters.
- `stall_cycles`, output, 32: stall-cycle counter.
- `lu_events`, `br_events`, output, 16 each: event counters.

## Operation
- All matches below require the register to be nonzero; `$0` never matches.
- `lu` = `MemtoReg_EX` and `WriteReg_EX` equals `rs_ID` or `rt_ID`.
- `bA` = `branch_ID` and `RegWrite_EX` and `WriteReg_EX` matches `rs_ID` or `rt_ID`.
- `bL` = `branch_ID` and `MemtoReg_MEM` and `WriteReg_MEM` matches `rs_ID` or `rt_ID`.
- `stall` = `lu` | `bA` | `bL`. `stall_IF` = `stall_ID` = `flush_EX` = `stall`. These are combinational from the inputs.
- `fwdA_ID` = `RegWrite_MEM` & !`MemtoReg_MEM` & (`WriteReg_MEM` == `rs_ID`). `fwdB_ID` is the same using `rt_ID`.
- `fwdA_EX`: 10 if `RegWrite_MEM` and `WriteReg_MEM` == `rs_EX`; else 01 if `RegWrite_WB` and `WriteReg_WB` == `rs_EX`; else 00. MEM has priority over WB. `fwdB_EX` is the same using `rt_EX`.
- FSM states: `RUN`, `LU`, `BR_ALU`, `BR_LD1`, `BR_LD2`.
  - From `RUN`:
    - to `BR_LD1` if `branch_ID` & `MemtoReg_EX` & match (this case also satisfies `bA`/`lu`);
    - else to `BR_ALU` if `bA`;
    - else to `BR_LD2` if `bL`;
    - else to `LU` if `lu`;
    - else stay in `RUN`.
  - `BR_LD1` goes to `BR_LD2` if `stall`, else to `RUN`.
  - `LU`, `BR_ALU` and `BR_LD2` each go to `RUN` if !`stall`; otherwise they stay.
  - A run counter increments on each stall cycle. When it exceeds `MAX_STALL`, `hazard_err` sets and stays set until reset.
- `stall_cause` is registered from the FSM state: `LU`→1, `BR_ALU`→2, `BR_LD1`/`BR_LD2`→3, `RUN`→0.

## Timing
- Stall, flush and forward outputs have zero latency: they are valid in the same cycle as their inputs.
- Load-use stall: 1 cycle. Branch on an ALU result in EX: 1 cycle. Branch on a load in EX: 2 cycles. Branch on a load in MEM: 1 cycle.
- `stall_cause` lags the stall by 1 cycle.
- On reset:
  - FSM goes to `RUN`, the run counter goes to 0, `hazard_err` clears, and all counters clear.
  - `stall_IF`, `stall_ID` and `flush_EX` are forced to 0 while `reset` is high.
  - Reset in the middle of a stall aborts the episode. No error is flagged.
- `perf_clr` clears the counters on the next edge. If it coincides with an increment, the clear wins.

## Configuration
- `HAZARD_PERF_CNT_EN` defined: `stall_cycles` increments on every stall cycle. `lu_events` and `br_events` increment on the `RUN`→`LU` and `RUN`→`BR_*` transitions respectively. All counters saturate at their maximum.
- Not defined: the counter ports still exist, are tied to 0, and no counter flops are built.

## Structure
- Shared package `mips_pkg`:
  - `REG_AW`;
  - forward-select constants `FWD_REG`, `FWD_WB`, `FWD_MEM`;
  - the `hz_state_t` enum;
  - `stall_cause` codes.
- Sub-module `hazard_perf_cnt` holds the three saturating counters. It is instantiated only under `HAZARD_PERF_CNT_EN`.

## Test plan
- `lw $8` in EX, `add` in ID reading `$8` → stall and flush high for 1 cycle, `stall_cause` = 1 on the next cycle, `lu_events` = 1.
- `add $9` in EX, `beq $9,$0` in ID → 1-cycle stall. Next cycle `fwdA_ID` = 1 and `stall_cause` = 2.
- `lw $10` in EX, `beq $10,$10` in ID → 2 consecutive stall cycles (`BR_LD1`→`BR_LD2`), `stall_cycles` = 2, `hazard_err` = 0.
- `lw $0` in EX, `add` reading `$0` in ID → no stall. `WriteReg_MEM` = `WriteReg_WB` = 5 with both `RegWrite` high and `rs_EX` = 5 → `fwdA_EX` = 10.
- Hold `lu` true for 3 cycles → `hazard_err` sets in cycle 3 and stays set. Assert `reset` mid-run → all outputs 0, FSM in `RUN`.
